// File: rtl/eq_sample_feeder.sv
// Sample feeder for the 8-band equalizer: buffers upstream samples in a FIFO and
// presents one sample per FRAME_LEN-phase frame, in lock-step with the equalizer counter.
module eq_sample_feeder #(
    parameter int FILTER_IN_BITS    = 16,
    parameter int FIFO_DEPTH        = 8,
    parameter int FRAME_LEN         = 64,
    parameter int COUNTER_BITS      = $clog2(FRAME_LEN),
    parameter int UNDERRUN_CNT_BITS = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             clk_enable,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic signed [FILTER_IN_BITS-1:0] in_sample,
    output logic signed [FILTER_IN_BITS-1:0] filter_in,
    output logic                             sample_strobe,
    output logic [$clog2(FIFO_DEPTH):0]      fifo_level,
    output logic                             underrun,
    output logic [UNDERRUN_CNT_BITS-1:0]     underrun_count,
    input  logic                             underrun_clear
);

    localparam int PTR_BITS = $clog2(FIFO_DEPTH);
    localparam int LVL_BITS = PTR_BITS + 1;
    localparam logic [COUNTER_BITS-1:0] LAST_PHASE = COUNTER_BITS'(FRAME_LEN - 1);
    localparam logic [LVL_BITS-1:0]     FULL_LEVEL = LVL_BITS'(FIFO_DEPTH);

    logic [COUNTER_BITS-1:0]          frame_count;
    logic [PTR_BITS-1:0]              wr_ptr;
    logic [PTR_BITS-1:0]              rd_ptr;
    logic signed [FILTER_IN_BITS-1:0] mem [FIFO_DEPTH];
    logic                             boundary;
    logic                             empty;
    logic                             push;
    logic                             pop;
    logic [LVL_BITS-1:0]              level_next;

    function automatic logic [UNDERRUN_CNT_BITS-1:0] sat_inc(
        input logic [UNDERRUN_CNT_BITS-1:0] v
    );
        return (&v) ? v : v + UNDERRUN_CNT_BITS'(1);
    endfunction

    assign in_ready = (fifo_level != FULL_LEVEL);
    assign empty    = (fifo_level == '0);
    assign boundary = clk_enable && (frame_count == LAST_PHASE);
    assign push     = in_valid && in_ready;
    // No bypass: a push into an empty FIFO on a boundary is not visible to that pop.
    assign pop      = boundary && !empty;

    always_comb begin
        level_next = fifo_level;
        case ({push, pop})
            2'b10:   level_next = fifo_level + LVL_BITS'(1);
            2'b01:   level_next = fifo_level - LVL_BITS'(1);
            default: level_next = fifo_level;
        endcase
    end

    // FIFO storage carries data only; pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_sample;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_count    <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_level     <= '0;
            filter_in      <= '0;
            sample_strobe  <= 1'b0;
            underrun       <= 1'b0;
            underrun_count <= '0;
        end else begin
            sample_strobe <= 1'b0;
            fifo_level    <= level_next;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_BITS'(1);
            end
            if (clk_enable) begin
                frame_count <= (frame_count == LAST_PHASE) ? '0 : frame_count + COUNTER_BITS'(1);
            end
            if (boundary) begin
                sample_strobe <= 1'b1;
                if (pop) begin
                    filter_in <= mem[rd_ptr];
                    rd_ptr    <= rd_ptr + PTR_BITS'(1);
                end else begin
                    filter_in <= '0;
                end
            end
            // An underrun in the same cycle as a clear restarts the count at one.
            if (boundary && empty) begin
                underrun       <= 1'b1;
                underrun_count <= underrun_clear ? UNDERRUN_CNT_BITS'(1) : sat_inc(underrun_count);
            end else if (underrun_clear) begin
                underrun       <= 1'b0;
                underrun_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_eq_sample_feeder.sv
// Directed bench for eq_sample_feeder: per-cycle vector table plus hand sequences
// for FIFO-full holdoff, boundary push, clk_enable toggling and mid-frame reset.
module tb_eq_sample_feeder;

    localparam int W = 16;

    typedef struct {
        int   rep;
        logic en;
        logic vld;
        int   smp;
        logic clr;
        int   filt;
        logic stb;
        int   lvl;
        logic rdy;
        logic urun;
        int   cnt;
    } vec_t;

    logic                clk = 1'b0;
    logic                rst;
    logic                clk_enable;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_sample;
    logic signed [W-1:0] filter_in;
    logic                sample_strobe;
    logic [3:0]          fifo_level;
    logic                underrun;
    logic [7:0]          underrun_count;
    logic                underrun_clear;

    int n_vec = 0;
    int n_err = 0;
    int fc = 0;
    vec_t vt[$];

    always #5 clk = ~clk;

    eq_sample_feeder dut (
        .clk(clk), .rst(rst), .clk_enable(clk_enable),
        .in_valid(in_valid), .in_ready(in_ready), .in_sample(in_sample),
        .filter_in(filter_in), .sample_strobe(sample_strobe), .fifo_level(fifo_level),
        .underrun(underrun), .underrun_count(underrun_count), .underrun_clear(underrun_clear)
    );

    function automatic vec_t mk(int rep, logic en, logic vld, int smp, logic clr,
                                int filt, logic stb, int lvl, logic rdy, logic urun, int cnt);
        vec_t v;
        v.rep = rep; v.en = en; v.vld = vld; v.smp = smp; v.clr = clr;
        v.filt = filt; v.stb = stb; v.lvl = lvl; v.rdy = rdy; v.urun = urun; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input int filt, input logic stb, input int lvl,
                              input logic rdy, input logic urun, input int cnt);
        check({tag, " filter_in"}, int'(filter_in), filt);
        check({tag, " sample_strobe"}, int'(sample_strobe), int'(stb));
        check({tag, " fifo_level"}, int'(fifo_level), lvl);
        check({tag, " in_ready"}, int'(in_ready), int'(rdy));
        check({tag, " underrun"}, int'(underrun), int'(urun));
        check({tag, " underrun_count"}, int'(underrun_count), cnt);
    endtask

    // One clock edge with the given inputs; the equalizer phase model advances alongside.
    task automatic tick(input logic en, input logic v, input int s, input logic clr);
        clk_enable     = en;
        in_valid       = v;
        in_sample      = W'(s);
        underrun_clear = clr;
        @(posedge clk);
        if (en) fc = (fc == 63) ? 0 : fc + 1;
        #1;
        check("frame_count", int'(dut.frame_count), fc);
    endtask

    task automatic to_boundary(input logic v, input int s);
        int guard = 0;
        while (fc != 63 && guard < 200) begin
            tick(1'b1, 1'b0, 0, 1'b0);
            guard++;
        end
        check("boundary reached", int'(fc == 63), 1);
        tick(1'b1, v, s, 1'b0);
    endtask

    initial begin
        int n;
        int stable_bad;
        bit seen;

        rst = 1'b1; clk_enable = 1'b0; in_valid = 1'b0; in_sample = '0; underrun_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outs("reset", 0, 1'b0, 0, 1'b1, 1'b0, 0);
        check("reset frame_count", int'(dut.frame_count), 0);
        @(negedge clk);
        rst = 1'b0;
        fc  = 0;

        // Three samples across frames, underruns, clear, saturation, clear-vs-event, fill to full.
        vt.push_back(mk(1, 1, 1, 100, 0,     0, 0, 1, 1, 0, 0));
        vt.push_back(mk(1, 1, 1, -200, 0,    0, 0, 2, 1, 0, 0));
        vt.push_back(mk(1, 1, 1, 300, 0,     0, 0, 3, 1, 0, 0));
        vt.push_back(mk(60, 1, 0, 0, 0,      0, 0, 3, 1, 0, 0));
        vt.push_back(mk(1, 1, 0, 0, 0,     100, 1, 2, 1, 0, 0));
        vt.push_back(mk(1, 1, 0, 0, 0,     100, 0, 2, 1, 0, 0));
        vt.push_back(mk(62, 1, 0, 0, 0,    100, 0, 2, 1, 0, 0));
        vt.push_back(mk(1, 1, 0, 0, 0,    -200, 1, 1, 1, 0, 0));
        vt.push_back(mk(63, 1, 0, 0, 0,   -200, 0, 1, 1, 0, 0));
        vt.push_back(mk(1, 1, 0, 0, 0,     300, 1, 0, 1, 0, 0));
        vt.push_back(mk(63, 1, 0, 0, 0,    300, 0, 0, 1, 0, 0));
        vt.push_back(mk(1, 1, 0, 0, 0,       0, 1, 0, 1, 1, 1));
        vt.push_back(mk(64, 1, 0, 0, 0,      0, 1, 0, 1, 1, 2));
        vt.push_back(mk(64, 1, 0, 0, 0,      0, 1, 0, 1, 1, 3));
        vt.push_back(mk(1, 1, 0, 0, 1,       0, 0, 0, 1, 0, 0));
        vt.push_back(mk(19199, 1, 0, 0, 0,   0, 1, 0, 1, 1, 255));
        vt.push_back(mk(63, 1, 0, 0, 0,      0, 0, 0, 1, 1, 255));
        vt.push_back(mk(1, 1, 0, 0, 1,       0, 1, 0, 1, 1, 1));
        vt.push_back(mk(1, 1, 0, 0, 1,       0, 0, 0, 1, 0, 0));
        for (int k = 1; k <= 8; k++)
            vt.push_back(mk(1, 1, 1, 10 + k, 0, 0, 0, k, (k != 8), 0, 0));
        vt.push_back(mk(54, 1, 1, 19, 0,     0, 0, 8, 0, 0, 0));
        vt.push_back(mk(1, 1, 1, 19, 0,     11, 1, 7, 1, 0, 0));
        vt.push_back(mk(1, 1, 1, 19, 0,     11, 0, 8, 0, 0, 0));

        foreach (vt[i]) begin
            for (int r = 0; r < vt[i].rep; r++) tick(vt[i].en, vt[i].vld, vt[i].smp, vt[i].clr);
            check_outs($sformatf("vec%0d", i), vt[i].filt, vt[i].stb, vt[i].lvl,
                       vt[i].rdy, vt[i].urun, vt[i].cnt);
        end

        // Drain the full FIFO: order preserved, held ninth sample last.
        for (int k = 12; k <= 19; k++) begin
            to_boundary(1'b0, 0);
            check_outs($sformatf("drain%0d", k), k, 1'b1, 19 - k, 1'b1, 1'b0, 0);
        end

        // Push on a boundary at level 1, then at level 0.
        tick(1'b1, 1'b1, 500, 1'b0);
        to_boundary(1'b1, 600);
        check_outs("bnd_push_l1", 500, 1'b1, 1, 1'b1, 1'b0, 0);
        to_boundary(1'b0, 0);
        check_outs("bnd_push_l1_next", 600, 1'b1, 0, 1'b1, 1'b0, 0);
        to_boundary(1'b1, 700);
        check_outs("bnd_push_l0", 0, 1'b1, 1, 1'b1, 1'b1, 1);
        to_boundary(1'b0, 0);
        check_outs("bnd_push_l0_next", 700, 1'b1, 0, 1'b1, 1'b1, 1);

        // Alternating clk_enable: push while disabled, next frame takes 128 clocks.
        tick(1'b0, 1'b1, 800, 1'b0);
        check("push while disabled level", int'(fifo_level), 1);
        n = 1;
        seen = 1'b0;
        stable_bad = 0;
        while (!seen && n < 300) begin
            n++;
            tick((n % 2) == 0, 1'b0, 0, 1'b0);
            if (sample_strobe) seen = 1'b1;
            else if (filter_in != 16'sd700) stable_bad++;
        end
        check("toggle strobe cycle", n, 128);
        check("toggle new sample", int'(filter_in), 800);
        check("toggle filter_in stable", stable_bad, 0);

        // Reset mid-frame with four samples queued.
        for (int k = 0; k < 4; k++) tick(1'b1, 1'b1, 1000 + k, 1'b0);
        while (fc != 37) tick(1'b1, 1'b0, 0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_outs("midreset", 0, 1'b0, 0, 1'b1, 1'b0, 0);
        check("midreset frame_count", int'(dut.frame_count), 0);
        @(negedge clk);
        rst = 1'b0;
        fc  = 0;
        tick(1'b1, 1'b1, 900, 1'b0);
        for (int k = 0; k < 62; k++) tick(1'b1, 1'b0, 0, 1'b0);
        check_outs("post_reset_frame0", 0, 1'b0, 1, 1'b1, 1'b0, 0);
        tick(1'b1, 1'b0, 0, 1'b0);
        check_outs("post_reset_frame1", 900, 1'b1, 0, 1'b1, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/eq_sample_feeder.md
Name: eq_sample_feeder

Overview:
- Upstream stage of the 8-band equalizer. Accepts audio samples over a valid/ready stream and buffers them in a small FIFO.
- Presents exactly one sample on the equalizer's filter_in for each 64-phase processing frame.
- Its frame counter runs in lock-step with the equalizer's internal phase counter: same clk, clk_enable and rst. The sample therefore changes only at the frame boundary.
- Flags and counts underruns when no sample is available at a frame boundary.

Parameters:
- FILTER_IN_BITS, 16, sample width; signed two's complement.
- FIFO_DEPTH, 8, FIFO entries; power of two, at least 2.
- FRAME_LEN, 64, clk_enable cycles per sample frame; must equal the equalizer counter span (COUNTER_MAX+1).
- COUNTER_BITS, $clog2(FRAME_LEN), frame counter width.
- UNDERRUN_CNT_BITS, 8, width of the saturating underrun counter.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- clk_enable, input, 1, advance enable; the same signal drives the equalizer.
- in_valid, input, 1, upstream sample valid.
- in_ready, output, 1, FIFO can accept a sample.
- in_sample, input, FILTER_IN_BITS, signed upstream sample.
- filter_in, output, FILTER_IN_BITS, signed sample held for the current frame; drives the equalizer.
- sample_strobe, output, 1, one-cycle pulse in the first cycle a new frame sample is on filter_in.
- fifo_level, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.
- underrun, output, 1, sticky underrun flag.
- underrun_count, output, UNDERRUN_CNT_BITS, saturating count of underruns.
- underrun_clear, input, 1, synchronous clear of underrun and underrun_count.

Behaviour:
- Reset (async, rst=1) sets:
  - frame_count=0, FIFO pointers=0, fifo_level=0.
  - filter_in=0, sample_strobe=0.
  - underrun=0, underrun_count=0.
  - in_ready=1 on release. in_ready is combinational: in_ready = (fifo_level != FIFO_DEPTH).
- Frame counter:
  - Increments on each clk with clk_enable=1.
  - Wraps from FRAME_LEN-1 to 0.
  - Holds when clk_enable=0.
  - After reset it matches the equalizer's current_count every cycle.
- Boundary event: clk_enable=1 and frame_count==FRAME_LEN-1.
  - If the FIFO is non-empty: pop the head into filter_in (visible the next cycle, together with frame_count=0) and assert sample_strobe=1 for that one cycle.
  - If the FIFO is empty: filter_in<=0, sample_strobe<=1, underrun<=1, underrun_count increments (saturating at all-ones).
- Outside a boundary event:
  - filter_in holds its value.
  - sample_strobe=0.
- filter_in is therefore stable for all FRAME_LEN enabled cycles of a frame. The first frame after reset carries 0 and does not count as an underrun.
- Push: in_valid && in_ready writes in_sample at the write pointer.
  - in_sample is not modified (no saturation or scaling).
  - Pointers wrap modulo FIFO_DEPTH.
- Simultaneous push and pop:
  - Both occur; fifo_level is unchanged.
  - When full, in_ready=0, so only the pop occurs. in_ready rises the cycle after the pop.
- No bypass: a sample pushed in the same cycle as a pop from an empty FIFO is not popped; that boundary is an underrun, and the sample is written and used at the next boundary.
- underrun_clear=1:
  - Clears underrun and underrun_count next cycle.
  - If an underrun event occurs in the same cycle, the event wins: underrun=1, count=1.
- in_sample is ignored when in_valid=0. in_valid with in_ready=0 is held off, not dropped. Upstream must keep data stable until accepted.
- clk_enable=0 freezes the frame counter and pops. Pushes still proceed.
- Reset mid-frame: all state clears immediately. FIFO contents are discarded, and counting restarts at 0 in step with the equalizer.

Test Plan:
- Reset, then push 3 samples 100, -200, 300 with clk_enable=1 constant → first frame filter_in=0. At the cycles where frame_count returns to 0 (64, 128, 192 after release), filter_in=100, -200, 300 with a one-cycle sample_strobe each. fifo_level goes 3→2→1→0. underrun=0.
- Push 9 samples back-to-back, FIFO_DEPTH=8 → in_ready=0 after the 8th accept and the 9th is held. At the next boundary pop, in_ready returns to 1 and the 9th is accepted. fifo_level peaks at 8, and no sample is lost or reordered.
- Empty FIFO across 3 boundaries → filter_in=0, underrun=1, underrun_count=3. Assert underrun_clear → count=0, flag=0. Repeat with 300 boundaries → count saturates at 255.
- Toggle clk_enable 1/0 alternately → a frame spans 128 clk cycles. filter_in changes only when frame_count wraps, and frame_count matches the equalizer's current_count every cycle.
- Push exactly on a boundary cycle with FIFO level=1 → one pop and one push, level stays 1, and order is preserved. Push on a boundary with level=0 → underrun recorded, and the sample appears at the following boundary.
- Assert rst at frame_count=37 with 4 samples queued → immediately filter_in=0, fifo_level=0, frame_count=0, in_ready=1. The next pushed sample appears 64 enabled cycles after release.
